fetch_sequencer: RTL and testbench

- Upstream end of the fetch interface. Generates the fetch PC and issues in-order requests to instruction memory.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them, tagged with their PC, to the fetch stage register.
- Drives the flush and hold controls that the fetch stage register consumes.
- Handles branch/jump redirects by discarding buffered instructions and responses still in flight.

---
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC generation, in-order imem requests, instruction buffer and redirect handling
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        flush,
  output logic        hold
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic          flush_q;

  logic [CW:0]   credit_used;
  logic          fifo_empty;
  logic          rsp_accept;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   target_aligned;

  // Credits cover both buffered entries and requests still owed by memory,
  // so a response always has a free buffer slot waiting for it.
  assign credit_used    = {1'b0, inflight} + {1'b0, count};
  assign fifo_empty     = (count == '0);
  assign target_aligned = redirect_target & ~32'h0000_0003;

  // A response with nothing outstanding is ignored entirely.
  assign rsp_accept = imem_rsp_valid && (inflight != '0);
  assign issue      = imem_req_valid && imem_req_ready;
  assign push       = rsp_accept && !redirect_valid && (drop == '0);
  assign pop        = !hold && !redirect_valid;

  assign imem_req_valid = !Reset && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;

  assign hold        = fifo_empty || stall || flush_q;
  assign flush       = flush_q;
  assign PC          = fifo_empty ? 32'h0000_0000 : pc_mem[rd_ptr];
  assign instruction = fifo_empty ? NOP : ins_mem[rd_ptr];

  // Buffer storage; contents are only observed while count is non-zero.
  always_ff @(posedge Clock) begin
    if (push) begin
      pc_mem[wr_ptr]  <= resp_pc;
      ins_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  // Outstanding-request and stale-response counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(rsp_accept);
      if (redirect_valid)
        drop <= inflight - CW'(rsp_accept);
      else if (rsp_accept && (drop != '0))
        drop <= drop - 1'b1;
    end
  end

  // Request and response address tracking plus the one-cycle flush pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= redirect_valid;
      if (redirect_valid) begin
        fetch_pc <= target_aligned;
        resp_pc  <= target_aligned;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vectors, corner sequences and randomized model check of fetch_sequencer
module tb_fetch_sequencer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        flush;
  logic        hold;

  always #5 Clock = ~Clock;

  fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .PC(PC), .instruction(instruction), .flush(flush), .hold(hold)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ctl = {redirect_valid, stall, imem_req_ready, imem_rsp_valid}; eflg = {req_valid, hold, flush}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] tgt;
    logic [31:0] rspd;
    logic [2:0]  eflg;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] eins;
  } vec_t;

  // Reference model: outstanding requests remember their own address and go
  // stale on a redirect; the buffer is a plain queue of {pc, instr}.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          stale;
  } req_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t        mq[$];
  ent_t        mf[$];
  logic [31:0] m_fetch;
  bit          m_fq;
  int          cyc;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          ready_pct = 100;
  logic        last_hold;
  logic [31:0] last_pc;

  task automatic model_reset();
    mq.delete();
    mf.delete();
    m_fetch = RESET_PC;
    m_fq    = 1'b0;
    cyc     = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, 32'({imem_req_valid, hold, flush}), 32'b010);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_instr"}, instruction, NOP);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    redirect_valid = 1'b0;
    stall = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    #2;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  // One cycle: memory drives its side, outputs are compared against the
  // model at the falling edge, then the model advances.
  task automatic tick();
    bit   e_empty, e_hold, e_req, issue;
    req_t r;
    imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge Clock);
    e_empty = (mf.size() == 0);
    e_hold  = e_empty || stall || m_fq;
    e_req   = !redirect_valid && (mq.size() + mf.size() < DEPTH);
    check("req_hold_flush", 32'({imem_req_valid, hold, flush}), 32'({e_req, e_hold, m_fq}));
    check("req_addr", imem_req_addr, m_fetch);
    check("pc", PC, e_empty ? 32'h0 : mf[0].pc);
    check("instr", instruction, e_empty ? NOP : mf[0].ins);
    last_hold = hold;
    last_pc   = PC;
    issue = e_req && imem_req_ready;
    if (!e_hold && !redirect_valid) void'(mf.pop_front());
    if (imem_rsp_valid) begin
      r = mq.pop_front();
      if (!r.stale && !redirect_valid) mf.push_back('{r.addr, r.data});
    end
    if (redirect_valid) begin
      mf.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_fetch = redirect_target & ~32'h3;
    end
    if (issue) begin
      mq.push_back('{m_fetch, $urandom, cyc + $urandom_range(lat_lo, lat_hi), 1'b0});
      m_fetch = m_fetch + 32'd4;
    end
    m_fq = redirect_valid;
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  // Advance until the fetch stage captures something, then compare its PC.
  task automatic wait_present(input string name, input logic [31:0] exp);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (!last_hold) found = 1'b1;
    end
    check(name, found ? last_pc : 32'hDEAD_BEEF, exp);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{4'b0010, 32'h0,   32'h0,         3'b110, 32'h00,  32'h0,   NOP};
    vecs[1]  = '{4'b0011, 32'h0,   32'hD000_0000, 3'b110, 32'h04,  32'h0,   NOP};
    vecs[2]  = '{4'b0011, 32'h0,   32'hD000_0004, 3'b100, 32'h08,  32'h0,   32'hD000_0000};
    vecs[3]  = '{4'b0111, 32'h0,   32'hD000_0008, 3'b110, 32'h0C,  32'h4,   32'hD000_0004};
    vecs[4]  = '{4'b0111, 32'h0,   32'hD000_000C, 3'b110, 32'h10,  32'h4,   32'hD000_0004};
    vecs[5]  = '{4'b0111, 32'h0,   32'hD000_0010, 3'b010, 32'h14,  32'h4,   32'hD000_0004};
    vecs[6]  = '{4'b0110, 32'h0,   32'h0,         3'b010, 32'h14,  32'h4,   32'hD000_0004};
    vecs[7]  = '{4'b0000, 32'h0,   32'h0,         3'b000, 32'h14,  32'h4,   32'hD000_0004};
    vecs[8]  = '{4'b0000, 32'h0,   32'h0,         3'b100, 32'h14,  32'h8,   32'hD000_0008};
    vecs[9]  = '{4'b0010, 32'h0,   32'h0,         3'b100, 32'h14,  32'hC,   32'hD000_000C};
    vecs[10] = '{4'b1011, 32'h203, 32'hD000_0014, 3'b000, 32'h18,  32'h10,  32'hD000_0010};
    vecs[11] = '{4'b0010, 32'h0,   32'h0,         3'b111, 32'h200, 32'h0,   NOP};
    vecs[12] = '{4'b0001, 32'h0,   32'hD000_0200, 3'b110, 32'h204, 32'h0,   NOP};
    vecs[13] = '{4'b0000, 32'h0,   32'h0,         3'b100, 32'h204, 32'h200, 32'hD000_0200};
    vecs[14] = '{4'b0001, 32'h0,   32'hD000_0BAD, 3'b110, 32'h204, 32'h0,   NOP};
    vecs[15] = '{4'b0000, 32'h0,   32'h0,         3'b110, 32'h204, 32'h0,   NOP};

    Reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    #12;
    check_reset_outputs("reset");
    redirect_valid = 1'b1;
    #1;
    check("reset_redirect_req", 32'(imem_req_valid), 32'h0);
    redirect_valid = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      {redirect_valid, stall, imem_req_ready, imem_rsp_valid} = vecs[i].ctl;
      redirect_target = vecs[i].tgt;
      imem_rsp_data   = vecs[i].rspd;
      @(negedge Clock);
      check($sformatf("vec%0d_flags", i), 32'({imem_req_valid, hold, flush}), 32'(vecs[i].eflg));
      check($sformatf("vec%0d_addr", i), imem_req_addr, vecs[i].eaddr);
      check($sformatf("vec%0d_pc", i), PC, vecs[i].epc);
      check($sformatf("vec%0d_instr", i), instruction, vecs[i].eins);
      @(posedge Clock);
      #1;
    end
    redirect_valid = 1'b0;
    stall = 1'b0;

    // Streaming from reset with 1-cycle memory.
    do_reset();
    for (int i = 0; i < 10; i++) tick();

    // Long stall fills the buffer, then drains in order.
    stall = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("stall_full_req", 32'(imem_req_valid), 32'h0);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Three requests in flight at latency 3, then redirect.
    lat_lo = 3;
    lat_hi = 3;
    for (int i = 0; i < 10 && mq.size() != 3; i++) tick();
    check("three_inflight", 32'(mq.size()), 32'd3);
    redirect_to(32'h100);
    wait_present("lat3_first_pc", 32'h100);
    wait_present("lat3_second_pc", 32'h104);

    // Redirect coinciding with a response, misaligned target, drop > 0.
    lat_lo = 2;
    lat_hi = 2;
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 10 && !(mq.size() > 0 && mq[0].due <= cyc); i++) tick();
    redirect_to(32'h203);
    wait_present("rsp_redirect_pc", 32'h200);

    // Back-to-back redirects: later target wins.
    lat_lo = 1;
    lat_hi = 3;
    for (int i = 0; i < 6; i++) tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_target = 32'h80;
    tick();
    redirect_valid  = 1'b0;
    wait_present("double_redirect_pc", 32'h80);

    // Reset mid-stream with two entries buffered.
    lat_lo = 1;
    lat_hi = 1;
    stall = 1'b1;
    redirect_to(32'h300);
    for (int i = 0; i < 3; i++) tick();
    check("prereset_pc", PC, 32'h300);
    Reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    stall = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
    wait_present("post_reset_pc", RESET_PC);

    // Randomized traffic.
    lat_lo = 1;
    lat_hi = 4;
    ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_target = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
